// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into one-cycle
// short / long / double press event pulses.
module press_classifier #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic debounced,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Gesture FSM: the counter measures the current high run in PRESS1 and
  // the current low run in WAIT_GAP; terminal compares come before increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (state)
        IDLE: begin
          if (debounced) begin
            state <= PRESS1;
            cnt   <= CNT_ONE;
          end
        end
        PRESS1: begin
          if (debounced) begin
            if (cnt == LONG_LAST) begin
              long_press <= 1'b1;
              state      <= LONG_HOLD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state <= WAIT_GAP;
            cnt   <= CNT_ONE;
          end
        end
        LONG_HOLD: begin
          if (!debounced) state <= IDLE;
        end
        WAIT_GAP: begin
          if (debounced) begin
            double_press <= 1'b1;
            state        <= PRESS2;
          end else if (cnt == GAP_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESS2: begin
          if (!debounced) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Busy is a pure decode of the state register.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed gesture scenarios plus a random stream,
// checked cycle by cycle against a run-length model of the gesture rules.
module tb_press_classifier;

  localparam int unsigned L = 8;
  localparam int unsigned G = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic debounced = 1'b0;
  logic short_press, long_press, double_press, busy;

  int errors = 0;
  int checks = 0;

  // Model: is a gesture open, how many presses it has seen, whether it
  // already went long, and the level / length of the current run.
  bit m_active = 0;
  int m_presses = 0;
  bit m_long = 0;
  bit m_level = 0;
  int m_run = 0;
  bit e_s, e_l, e_d;

  // Observed pulse counts for the current scenario and previous-cycle pulses.
  int n_s, n_l, n_d;
  logic p_s = 1'b0, p_l = 1'b0, p_d = 1'b0;

  press_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .debounced(debounced),
    .short_press(short_press),
    .long_press(long_press),
    .double_press(double_press),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one sample of the gesture rules to the model.
  task automatic model(input bit d, input bit r);
    bit changed;
    e_s = 0; e_l = 0; e_d = 0;
    if (r) begin
      m_active = 0;
    end else if (!m_active) begin
      if (d) begin
        m_active = 1; m_presses = 1; m_long = 0; m_level = 1; m_run = 1;
      end
    end else begin
      changed = (d != m_level);
      if (changed) begin m_level = d; m_run = 1; end
      else m_run++;
      if (m_presses == 1 && !m_long) begin
        if (d && changed) begin
          e_d = 1; m_presses = 2;
        end else if (d && m_run == int'(L)) begin
          e_l = 1; m_long = 1;
        end else if (!d && m_run == int'(G)) begin
          e_s = 1; m_active = 0;
        end
      end else if (!d) begin
        m_active = 0;
      end
    end
  endtask

  // Drive one sample, clock it in, then compare every output to the model.
  task automatic step(input bit d, input bit r);
    debounced = d;
    reset = r;
    @(posedge clk);
    #1;
    model(d, r);
    chk("short", short_press, e_s);
    chk("long", long_press, e_l);
    chk("double", double_press, e_d);
    chk("busy", busy, m_active);
    chk("onehot", $onehot0({short_press, long_press, double_press}), 1'b1);
    chk("width", (p_s & short_press) | (p_l & long_press) | (p_d & double_press), 1'b0);
    p_s = short_press; p_l = long_press; p_d = double_press;
    n_s += int'(short_press); n_l += int'(long_press); n_d += int'(double_press);
  endtask

  task automatic clr;
    n_s = 0; n_l = 0; n_d = 0;
  endtask

  initial begin
    int left;
    bit lvl;

    // Reset state
    step(0, 1);
    step(1, 1);
    chk("rst_short", short_press, 1'b0);
    chk("rst_long", long_press, 1'b0);
    chk("rst_double", double_press, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Scenario 1: short press
    clr();
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      if (i == 4) chk("s1_busy_before", busy, 1'b1);
      if (i == 5) begin
        chk("s1_short_at5", short_press, 1'b1);
        chk("s1_busy_drop", busy, 1'b0);
      end
    end
    chk_int("s1_n_short", n_s, 1);
    chk_int("s1_n_long", n_l, 0);
    chk_int("s1_n_double", n_d, 0);

    // Scenario 2: long press
    clr();
    for (int i = 1; i <= 20; i++) begin
      step(1, 0);
      if (i == 7) chk("s2_long_at7", long_press, 1'b0);
      if (i == 8) chk("s2_long_at8", long_press, 1'b1);
    end
    step(0, 0);
    chk("s2_busy_release", busy, 1'b0);
    for (int i = 0; i < 6; i++) step(0, 0);
    chk_int("s2_n_long", n_l, 1);
    chk_int("s2_n_short", n_s, 0);

    // Scenario 3: double press
    clr();
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 2; i++) step(0, 0);
    step(1, 0);
    chk("s3_double", double_press, 1'b1);
    step(1, 0);
    step(1, 0);
    chk("s3_busy_held", busy, 1'b1);
    step(0, 0);
    chk("s3_busy_release", busy, 1'b0);
    for (int i = 0; i < 8; i++) step(0, 0);
    chk_int("s3_n_double", n_d, 1);
    chk_int("s3_n_short", n_s, 0);

    // Scenario 4: press right after short_press starts a new gesture
    clr();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) step(1, 0);
      for (int i = 0; i < 5; i++) step(0, 0);
    end
    chk_int("s4_n_short", n_s, 2);
    chk_int("s4_n_double", n_d, 0);

    // Scenario 5: reset in the middle of a held press
    clr();
    for (int i = 0; i < 7; i++) step(1, 0);
    step(1, 1);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_long", long_press, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 0);
      if (i == 7) chk("s5_long_at7", long_press, 1'b0);
      if (i == 8) chk("s5_long_at8", long_press, 1'b1);
    end
    step(0, 0);
    chk_int("s5_n_long", n_l, 1);

    // Scenario 6: random runs with occasional reset
    left = 0;
    lvl = 0;
    for (int i = 0; i < 10000; i++) begin
      if (left == 0) begin
        lvl = $urandom_range(0, 1) == 1;
        left = $urandom_range(1, 12);
      end
      left--;
      step(lvl, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
